// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btb_update_ctrl
// Description : BTB storage owner: queues EX updates, sequences read-modify-
//               write through the set-update logic, arbitrates the read port
//               against IF lookups and runs whole-table flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_update_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         lk_valid,
    input  logic [2:0]   lk_index,
    output logic         lk_stall,
    output logic         lk_set_valid,
    output logic [127:0] lk_set,
    input  logic         upd_valid,
    output logic         upd_ready,
    input  logic [31:0]  upd_pc,
    input  logic [31:0]  upd_target,
    input  logic         upd_mispred,
    output logic [127:0] update_set,
    output logic [26:0]  update_tag,
    output logic [2:0]   update_index,
    output logic [31:0]  update_target,
    output logic         mispredicted,
    output logic [7:0]   LRU,
    input  logic [127:0] write_set,
    input  logic         next_LRU_write,
    input  logic         flush_req,
    output logic         flush_busy,
    output logic         flush_done
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_SW = $clog2(STARVE_MAX + 1);
    localparam logic [c_AW:0]   c_PTR_ONE    = 1;
    localparam logic [c_SW-1:0] c_STARVE_ONE = 1;
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [127:0]    r_sets [8];
    logic [7:0]      r_lru;
    logic [29:0]     r_q_pc  [FIFO_DEPTH];
    logic [31:0]     r_q_tgt [FIFO_DEPTH];
    logic            r_q_mis [FIFO_DEPTH];
    logic [c_AW:0]   r_wr_ptr, r_rd_ptr;
    logic [c_SW-1:0] r_starve, w_starve_nxt;
    logic [2:0]      r_flush_cnt;
    logic            r_flush_pend;
    logic            r_flush_done;
    logic            r_lk_valid;
    logic [127:0]    r_lk_set;
    logic [127:0]    r_upd_set;
    logic [26:0]     r_upd_tag;
    logic [2:0]      r_upd_index;
    logic [31:0]     r_upd_tgt;
    logic            r_upd_mis;

    logic            w_empty, w_full, w_push, w_pop;
    logic            w_flush_acc, w_flush_go, w_flush_enter;
    logic            w_lk_stall, w_lk_acc;
    logic [127:0]    w_lk_data;
    logic [29:0]     w_head_pc;
    logic [2:0]      w_head_index;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                          (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push       = upd_valid && !w_full;
    assign w_head_pc    = r_q_pc[r_rd_ptr[c_AW-1:0]];
    assign w_head_index = w_head_pc[2:0];

    assign flush_busy   = r_flush_pend || (r_state == ST_FLUSH);
    assign w_flush_acc  = flush_req && !flush_busy;
    assign w_flush_go   = w_flush_acc || r_flush_pend;

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_lk_stall   = 1'b0;
        w_starve_nxt = r_starve;
        unique case (r_state)
            ST_IDLE: begin
                if (w_flush_go)
                    w_state_nxt = ST_FLUSH;
                else if (!w_empty)
                    w_state_nxt = ST_READ;
            end
            ST_READ: begin
                // A flush aborts the read before it pops, so the entry is dropped by the flush.
                if (w_flush_go) begin
                    w_state_nxt  = ST_FLUSH;
                    w_starve_nxt = '0;
                end else if (!lk_valid || (r_starve == c_STARVE_MAX)) begin
                    w_lk_stall   = lk_valid;
                    w_pop        = 1'b1;
                    w_state_nxt  = ST_WRITE;
                    w_starve_nxt = '0;
                end else begin
                    w_starve_nxt = r_starve + c_STARVE_ONE;
                end
            end
            ST_WRITE: begin
                if (w_flush_go)
                    w_state_nxt = ST_FLUSH;
                else if (!w_empty)
                    w_state_nxt = ST_READ;
                else
                    w_state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                if (r_flush_cnt == 3'd7)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_flush_enter = (w_state_nxt == ST_FLUSH) && (r_state != ST_FLUSH);
    assign w_lk_acc      = lk_valid && !w_lk_stall;

    always_comb begin
        w_lk_data = r_sets[lk_index];
        if (r_state == ST_FLUSH)
            w_lk_data = '0;
        else if ((r_state == ST_WRITE) && (lk_index == r_upd_index))
            w_lk_data = write_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_starve     <= '0;
            r_flush_cnt  <= '0;
            r_flush_pend <= 1'b0;
            r_flush_done <= 1'b0;
            r_lk_valid   <= 1'b0;
            r_lk_set     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve     <= w_starve_nxt;
            r_flush_cnt  <= (r_state == ST_FLUSH) ? r_flush_cnt + 3'd1 : 3'd0;
            r_flush_pend <= (r_flush_pend || w_flush_acc) && !w_flush_enter;
            r_flush_done <= (r_state == ST_FLUSH) && (r_flush_cnt == 3'd7);
            r_lk_valid   <= w_lk_acc;
            if (w_lk_acc)
                r_lk_set <= w_lk_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_pc[i]  <= '0;
                r_q_tgt[i] <= '0;
                r_q_mis[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_q_pc[r_wr_ptr[c_AW-1:0]]  <= upd_pc[31:2];
                r_q_tgt[r_wr_ptr[c_AW-1:0]] <= upd_target;
                r_q_mis[r_wr_ptr[c_AW-1:0]] <= upd_mispred;
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            // Entering a flush discards everything queued so far; a push on this edge survives.
            if (w_flush_enter)
                r_rd_ptr <= r_wr_ptr;
            else if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_set   <= '0;
            r_upd_tag   <= '0;
            r_upd_index <= '0;
            r_upd_tgt   <= '0;
            r_upd_mis   <= 1'b0;
        end else if (w_pop) begin
            r_upd_set   <= r_sets[w_head_index];
            r_upd_tag   <= w_head_pc[29:3];
            r_upd_index <= w_head_index;
            r_upd_tgt   <= r_q_tgt[r_rd_ptr[c_AW-1:0]];
            r_upd_mis   <= r_q_mis[r_rd_ptr[c_AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                r_sets[i] <= '0;
            r_lru <= '0;
        end else begin
            if (r_state == ST_FLUSH)
                r_sets[r_flush_cnt] <= '0;
            else if (r_state == ST_WRITE)
                r_sets[r_upd_index] <= write_set;
            if (w_flush_enter)
                r_lru <= '0;
            else if (r_state == ST_WRITE)
                r_lru[r_upd_index] <= next_LRU_write;
        end
    end

    assign lk_stall      = w_lk_stall;
    assign lk_set_valid  = r_lk_valid;
    assign lk_set        = r_lk_set;
    assign upd_ready     = !w_full;
    assign update_set    = r_upd_set;
    assign update_tag    = r_upd_tag;
    assign update_index  = r_upd_index;
    assign update_target = r_upd_tgt;
    assign mispredicted  = r_upd_mis;
    assign LRU           = r_lru;
    assign flush_done    = r_flush_done;

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_update_ctrl
// Description : Directed and randomized bench for btb_update_ctrl against a
//               transaction-level table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_update_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         lk_valid;
    logic [2:0]   lk_index;
    logic         lk_stall;
    logic         lk_set_valid;
    logic [127:0] lk_set;
    logic         upd_valid;
    logic         upd_ready;
    logic [31:0]  upd_pc;
    logic [31:0]  upd_target;
    logic         upd_mispred;
    logic [127:0] update_set;
    logic [26:0]  update_tag;
    logic [2:0]   update_index;
    logic [31:0]  update_target;
    logic         mispredicted;
    logic [7:0]   LRU;
    logic [127:0] write_set;
    logic         next_LRU_write;
    logic         flush_req;
    logic         flush_busy;
    logic         flush_done;

    int checks = 0;
    int errors = 0;

    logic [127:0] m_sets [8];
    logic [7:0]   m_lru;

    always #5 clk = ~clk;

    btb_update_ctrl #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_index(lk_index), .lk_stall(lk_stall),
        .lk_set_valid(lk_set_valid), .lk_set(lk_set),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_mispred(upd_mispred),
        .update_set(update_set), .update_tag(update_tag), .update_index(update_index),
        .update_target(update_target), .mispredicted(mispredicted), .LRU(LRU),
        .write_set(write_set), .next_LRU_write(next_LRU_write),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
    );

    // Stand-in for the set-update logic; the model applies the same rule per update.
    function automatic logic [127:0] fset(input logic [127:0] s, input logic [26:0] tag,
                                          input logic [31:0] tgt, input logic mis);
        return {s[94:0], mis, tgt ^ {5'b0, tag}};
    endfunction

    function automatic logic flru(input logic [31:0] tgt, input logic mis);
        return ~mis ^ tgt[2];
    endfunction

    assign write_set      = fset(update_set, update_tag, update_target, mispredicted);
    assign next_LRU_write = flru(update_target, mispredicted);

    task automatic model_apply(input logic [31:0] pc, input logic [31:0] tgt, input logic mis);
        m_sets[pc[4:2]] = fset(m_sets[pc[4:2]], pc[31:5], tgt, mis);
        m_lru[pc[4:2]]  = flru(tgt, mis);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_sets[i] = '0;
        m_lru = '0;
    endtask

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic mis);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_target  = tgt;
        upd_mispred = mis;
    endtask

    task automatic push_wait(input logic [31:0] pc, input logic [31:0] tgt, input logic mis);
        logic ok;
        ok = 1'b0;
        set_upd(pc, tgt, mis);
        for (int n = 0; n < 50 && !ok; n++) begin
            #1;
            ok = upd_ready;
            tick();
        end
        upd_valid = 1'b0;
        if (ok) model_apply(pc, tgt, mis);
        else chk("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_lookup(input logic [2:0] idx, input logic [127:0] exp, input string name);
        lk_valid = 1'b1;
        lk_index = idx;
        tick();
        lk_valid = 1'b0;
        chk(name, lk_set, exp);
    endtask

    task automatic check_table(input string pfx);
        for (int i = 0; i < 8; i++)
            do_lookup(3'(i), m_sets[i], $sformatf("%s_set%0d", pfx, i));
        chk({pfx, "_lru"}, LRU, m_lru);
    endtask

    initial begin
        int   pushes;
        logic acc;
        logic [31:0] pa, pb, pc, pd, pe;

        rst_n = 1'b0; lk_valid = 1'b0; lk_index = '0; upd_valid = 1'b0;
        upd_pc = '0; upd_target = '0; upd_mispred = 1'b0; flush_req = 1'b0;
        model_clear();
        tick(); tick();
        chk("rst_lk_stall", lk_stall, 1'b0);
        chk("rst_lk_set_valid", lk_set_valid, 1'b0);
        chk("rst_lk_set", lk_set, '0);
        chk("rst_upd_ready", upd_ready, 1'b1);
        chk("rst_flush_busy", flush_busy, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_lru", LRU, '0);
        chk("rst_update_tag", update_tag, '0);
        rst_n = 1'b1;
        tick();

        // Single update: WRITE two edges after the push
        set_upd(32'h0000_0104, 32'h0000_0200, 1'b1);
        tick();
        upd_valid = 1'b0;
        tick();
        chk("t1_before_write_tag", update_tag, '0);
        tick();
        chk("t1_tag", update_tag, 27'h0000008);
        chk("t1_index", update_index, 3'd1);
        chk("t1_target", update_target, 32'h200);
        chk("t1_mispred", mispredicted, 1'b1);
        chk("t1_update_set", update_set, '0);
        model_apply(32'h0000_0104, 32'h0000_0200, 1'b1);
        tick();
        chk("t1_lru", LRU, m_lru);
        do_lookup(3'd1, m_sets[1], "t1_lookup_set1");

        // Back-to-back pushes into a 2-deep queue
        pa = 32'hA000_0010; pb = 32'hB000_0018; pc = 32'hC000_0030;
        set_upd(pa, 32'h1111_1114, 1'b0);
        chk("t2_ready_empty", upd_ready, 1'b1);
        tick();
        set_upd(pb, 32'h2222_2220, 1'b1);
        tick();
        chk("t2_ready_full", upd_ready, 1'b0);
        set_upd(pc, 32'h3333_3334, 1'b1);
        tick();
        chk("t2_write_a", update_tag, {5'b0, pa[31:5]});
        chk("t2_ready_after_pop", upd_ready, 1'b1);
        tick();
        upd_valid = 1'b0;
        tick();
        chk("t2_write_b", update_tag, {5'b0, pb[31:5]});
        tick(); tick();
        chk("t2_write_c", update_tag, {5'b0, pc[31:5]});
        model_apply(pa, 32'h1111_1114, 1'b0);
        model_apply(pb, 32'h2222_2220, 1'b1);
        model_apply(pc, 32'h3333_3334, 1'b1);
        repeat (4) tick();
        do_lookup(3'd4, m_sets[4], "t2_lookup_set4");
        do_lookup(3'd6, m_sets[6], "t2_lookup_set6");

        // Starvation: continuous lookups against one queued update
        pd = 32'hD000_0008;
        set_upd(pd, 32'h0000_4444, 1'b0);
        lk_valid = 1'b1; lk_index = 3'd4;
        tick();
        upd_valid = 1'b0;
        tick();
        chk("t3_lookup_data", lk_set, m_sets[4]);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t3_no_stall_%0d", k), lk_stall, 1'b0);
            tick();
        end
        chk("t3_stall", lk_stall, 1'b1);
        tick();
        chk("t3_update_wins", update_tag, {5'b0, pd[31:5]});
        chk("t3_stalled_not_valid", lk_set_valid, 1'b0);
        chk("t3_stall_released", lk_stall, 1'b0);
        lk_valid = 1'b0;
        model_apply(pd, 32'h0000_4444, 1'b0);
        repeat (3) tick();

        // Same-index lookup during WRITE returns the set being written
        pe = 32'hE000_000C;
        set_upd(pe, 32'h5555_5550, 1'b1);
        tick();
        upd_valid = 1'b0;
        tick(); tick();
        lk_valid = 1'b1; lk_index = 3'd3;
        model_apply(pe, 32'h5555_5550, 1'b1);
        tick();
        lk_valid = 1'b0;
        chk("t4_bypass", lk_set, m_sets[3]);
        chk("t4_bypass_valid", lk_set_valid, 1'b1);
        tick();
        chk("t4_lru", LRU, m_lru);

        // Randomized updates interleaved with random lookups
        pushes = 0;
        for (int c = 0; c < 300; c++) begin
            lk_valid    = ($urandom_range(0, 2) == 0);
            lk_index    = 3'($urandom);
            upd_valid   = (pushes < 40) && ($urandom_range(0, 1) == 1);
            upd_pc      = $urandom;
            upd_target  = $urandom;
            upd_mispred = 1'($urandom);
            #1;
            acc = upd_valid && upd_ready;
            tick();
            if (acc) begin
                model_apply(upd_pc, upd_target, upd_mispred);
                pushes++;
            end
        end
        upd_valid = 1'b0; lk_valid = 1'b0;
        repeat (20) tick();
        check_table("rand");

        // Flush aborting a READ, with a push during FLUSH and an ignored second request
        for (int i = 0; i < 8; i++)
            push_wait({24'h77_0000, 3'(i), 5'b0} | (32'(i) << 2), 32'h9000_0000 + 32'(i), 1'(i));
        repeat (20) tick();
        set_upd(32'hF000_0014, 32'h0000_6666, 1'b0);
        tick();
        upd_valid = 1'b0;
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        model_clear();
        chk("t5_busy", flush_busy, 1'b1);
        chk("t5_lru_cleared", LRU, '0);
        lk_valid = 1'b1; lk_index = 3'd7;
        tick();
        lk_valid = 1'b0;
        chk("t5_lookup_in_flush", lk_set, '0);
        set_upd(32'h1234_5008, 32'h0000_7777, 1'b1);
        tick();
        upd_valid = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (4) tick();
        chk("t5_done_early", flush_done, 1'b0);
        tick();
        chk("t5_done", flush_done, 1'b1);
        chk("t5_busy_dropped", flush_busy, 1'b0);
        tick();
        chk("t5_done_pulse", flush_done, 1'b0);
        model_apply(32'h1234_5008, 32'h0000_7777, 1'b1);
        repeat (10) tick();
        check_table("flush");

        // Asynchronous reset in the middle of a WRITE
        do_lookup(3'd2, m_sets[2], "t6_pre_lookup");
        set_upd(32'h8765_4318, 32'h0000_8888, 1'b1);
        tick();
        upd_valid = 1'b0;
        tick(); tick();
        chk("t6_in_write", update_tag, 27'h43B2A18);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tag", update_tag, '0);
        chk("t6_index", update_index, '0);
        chk("t6_target", update_target, '0);
        chk("t6_mispred", mispredicted, 1'b0);
        chk("t6_update_set", update_set, '0);
        chk("t6_lk_set", lk_set, '0);
        chk("t6_lk_set_valid", lk_set_valid, 1'b0);
        chk("t6_lru", LRU, '0);
        chk("t6_ready", upd_ready, 1'b1);
        chk("t6_busy", flush_busy, 1'b0);
        tick();
        rst_n = 1'b1;
        model_clear();
        tick();
        do_lookup(3'd2, m_sets[2], "t6_set2_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
